// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding, word geometry
// and the default load address.
package mips_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } ld_state_e;

   localparam int          WORD_BYTES        = 4;
   localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0;

endpackage

// File: rtl/imem_byte_packer.sv
// Shifts accepted bytes into a 32-bit word, MSB first; flags the 4th byte of each word.
module imem_byte_packer (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        accept,
   input  logic [7:0]  byte_data,
   output logic [31:0] word,
   output logic        word_full
);

   logic [1:0]  idx_q;
   logic [31:0] word_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx_q  <= 2'd0;
         word_q <= 32'h0;
      end else if (clear) begin
         idx_q  <= 2'd0;
         word_q <= 32'h0;
      end else if (accept) begin
         word_q <= {word_q[23:0], byte_data};
         idx_q  <= idx_q + 2'd1;
      end
   end

   assign word      = word_q;
   assign word_full = accept && (idx_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Fills instruction memory from a byte stream: packs big-endian words, writes them to
// consecutive addresses, and holds the CPU while the load runs.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; rejects over-long loads with err
// ST_LOAD  | accepting bytes until a full word is assembled
// ST_WRITE | one-cycle memory write, bump address/checksum/count
// ST_DONE  | one-cycle done pulse, CPU released
module imem_loader
   import mips_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
   parameter int          DEPTH_WORDS = 256,
   parameter int          LEN_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [LEN_W-1:0] len_words,
   input  logic             byte_valid,
   input  logic [7:0]       byte_data,
   output logic             byte_ready,
   output logic             imem_we,
   output logic [31:0]      imem_addr,
   output logic [31:0]      imem_wdata,
   output logic             cpu_hold,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [31:0]      checksum
);

   localparam logic [LEN_W:0] DEPTH_L = (LEN_W+1)'(DEPTH_WORDS);

   ld_state_e        state_q, state_d;
   logic [LEN_W-1:0] words_left_q, words_left_d;
   logic [31:0]      addr_q, addr_d;
   logic [31:0]      checksum_q, checksum_d;
   logic             err_q, err_d;
   logic             pk_clear;
   logic             accept;
   logic [31:0]      word;
   logic             word_full;

   assign accept = byte_valid && byte_ready;

   imem_byte_packer u_packer (
      .clk       (clk),
      .rst       (rst),
      .clear     (pk_clear),
      .accept    (accept),
      .byte_data (byte_data),
      .word      (word),
      .word_full (word_full)
   );

   always_comb begin
      state_d      = state_q;
      words_left_d = words_left_q;
      addr_d       = addr_q;
      checksum_d   = checksum_q;
      err_d        = 1'b0;
      pk_clear     = 1'b0;
      byte_ready   = 1'b0;
      imem_we      = 1'b0;
      done         = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (len_words == '0) begin
                  state_d = ST_DONE;
               end else if ({1'b0, len_words} > DEPTH_L) begin
                  err_d = 1'b1;
               end else begin
                  state_d      = ST_LOAD;
                  words_left_d = len_words;
                  addr_d       = BASE_ADDR;
                  checksum_d   = 32'h0;
                  pk_clear     = 1'b1;
               end
            end
         end
         ST_LOAD: begin
            byte_ready = 1'b1;
            if (word_full) state_d = ST_WRITE;
         end
         ST_WRITE: begin
            imem_we      = 1'b1;
            checksum_d   = checksum_q ^ word;
            addr_d       = addr_q + 32'(WORD_BYTES);
            words_left_d = words_left_q - LEN_W'(1);
            state_d      = (words_left_q == LEN_W'(1)) ? ST_DONE : ST_LOAD;
         end
         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         words_left_q <= '0;
         addr_q       <= BASE_ADDR;
         checksum_q   <= 32'h0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         words_left_q <= words_left_d;
         addr_q       <= addr_d;
         checksum_q   <= checksum_d;
         err_q        <= err_d;
      end
   end

   assign imem_addr  = addr_q;
   assign imem_wdata = word;
   assign checksum   = checksum_q;
   assign err        = err_q;
   assign busy       = (state_q != ST_IDLE);
   assign cpu_hold   = (state_q == ST_LOAD) || (state_q == ST_WRITE);

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader: a program model predicts every memory
// write, and a monitor on the falling edge checks each write strobe against it.
module tb_imem_loader;

   localparam int          DEPTH = 8;
   localparam int          LW    = 16;
   localparam logic [31:0] BASE  = 32'h0;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [LW-1:0] len_words = '0;
   logic          byte_valid = 1'b0;
   logic [7:0]    byte_data = 8'h0;
   logic          byte_ready, imem_we, cpu_hold, busy, done, err;
   logic [31:0]   imem_addr, imem_wdata, checksum;

   imem_loader #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LEN_W(LW)) dut (
      .clk(clk), .rst(rst), .start(start), .len_words(len_words),
      .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err), .checksum(checksum)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int done_seen = 0;
   int err_seen = 0;
   logic [31:0] exp_addr[$];
   logic [31:0] exp_data[$];
   logic [7:0]  prog[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Monitor: every write strobe must match the oldest predicted write.
   always @(negedge clk) begin
      if (!rst) begin
         if (imem_we) begin
            checks++;
            if (exp_addr.size() == 0) begin
               errors++;
               $display("FAIL unexpected_write actual=%h:%h required=none", imem_addr, imem_wdata);
            end else begin
               logic [31:0] ea, ed;
               ea = exp_addr.pop_front();
               ed = exp_data.pop_front();
               if (imem_addr !== ea || imem_wdata !== ed) begin
                  errors++;
                  $display("FAIL write actual=%h:%h required=%h:%h", imem_addr, imem_wdata, ea, ed);
               end
            end
         end
         if (done) done_seen++;
         if (err)  err_seen++;
      end
   end

   task automatic pulse_start(input int len);
      start = 1'b1;
      len_words = LW'(len);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Offer one byte and hold it until the handshake completes.
   task automatic send_byte(input logic [7:0] b, input int gap_mode, input bit spur, input bit last);
      bit acc;
      int n, g;
      byte_valid = 1'b1;
      byte_data  = b;
      n = 0;
      forever begin
         acc = byte_ready;
         if (spur && $urandom_range(0, 3) == 0) begin
            start = 1'b1;
            len_words = LW'($urandom_range(0, DEPTH + 2));
         end
         @(posedge clk); #1;
         start = 1'b0;
         if (acc) break;
         n++;
         if (n > 40) begin
            checks++; errors++;
            $display("FAIL byte_timeout actual=no_ready required=ready");
            break;
         end
      end
      byte_valid = 1'b0;
      if (!last) begin
         g = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 3)) : 0;
         for (int i = 0; i < g; i++) begin
            byte_data = 8'($urandom);
            @(posedge clk); #1;
         end
      end
   endtask

   // Loads prog[0 .. 4*len-1]; the model predicts words, addresses and checksum.
   task automatic run_load(input int len, input int gap_mode, input bit spur);
      logic [31:0] w, cs;
      int base_done;
      cs = 32'h0;
      for (int i = 0; i < len; i++) begin
         w = {prog[4*i], prog[4*i+1], prog[4*i+2], prog[4*i+3]};
         exp_addr.push_back(BASE + 32'(4 * i));
         exp_data.push_back(w);
         cs ^= w;
      end
      base_done = done_seen;
      pulse_start(len);
      check("hold_on_load", {31'b0, cpu_hold}, 32'd1);
      check("busy_on_load", {31'b0, busy}, 32'd1);
      for (int k = 0; k < 4 * len; k++)
         send_byte(prog[k], gap_mode, spur, k == 4 * len - 1);
      // one cycle after the last byte: the write cycle
      check("last_write_we", {31'b0, imem_we}, 32'd1);
      check("ready_in_write", {31'b0, byte_ready}, 32'd0);
      check("done_early", {31'b0, done}, 32'd0);
      @(posedge clk); #1;
      check("done_latency", {31'b0, done}, 32'd1);
      check("hold_at_done", {31'b0, cpu_hold}, 32'd0);
      check("busy_at_done", {31'b0, busy}, 32'd1);
      check("checksum", checksum, cs);
      check("addr_after", imem_addr, BASE + 32'(4 * len));
      @(posedge clk); #1;
      check("busy_idle", {31'b0, busy}, 32'd0);
      check("writes_left", 32'(exp_addr.size()), 32'd0);
      check("done_count", 32'(done_seen), 32'(base_done + 1));
   endtask

   task automatic fill_random(input int len);
      prog.delete();
      for (int i = 0; i < 4 * len; i++) prog.push_back(8'($urandom));
   endtask

   initial begin
      int len;
      #3;
      check("rst_ready", {31'b0, byte_ready}, 32'd0);
      check("rst_we", {31'b0, imem_we}, 32'd0);
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_addr", imem_addr, BASE);
      check("rst_wdata", imem_wdata, 32'h0);
      check("rst_checksum", checksum, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // directed two-word program, valid held
      prog = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
      run_load(2, 0, 1'b0);
      check("directed_checksum", checksum, 32'hAC010001);

      // valid toggled every other cycle
      prog = '{8'h12, 8'h34, 8'h56, 8'h78};
      run_load(1, 1, 1'b0);

      // too long -> err, stays idle
      pulse_start(DEPTH + 1);
      check("err_pulse", {31'b0, err}, 32'd1);
      check("err_busy", {31'b0, busy}, 32'd0);
      @(posedge clk); #1;
      check("err_single", {31'b0, err}, 32'd0);
      check("err_idle", {31'b0, busy}, 32'd0);
      check("err_count", 32'(err_seen), 32'd1);

      // zero length -> done without writes
      pulse_start(0);
      check("zero_done", {31'b0, done}, 32'd1);
      check("zero_busy", {31'b0, busy}, 32'd1);
      check("zero_hold", {31'b0, cpu_hold}, 32'd0);
      @(posedge clk); #1;
      check("zero_idle", {31'b0, busy}, 32'd0);

      // full-depth load is accepted
      fill_random(DEPTH);
      run_load(DEPTH, 2, 1'b1);

      // reset in the middle of the first word
      fill_random(3);
      pulse_start(3);
      send_byte(prog[0], 0, 1'b0, 1'b0);
      send_byte(prog[1], 0, 1'b0, 1'b0);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_ready", {31'b0, byte_ready}, 32'd0);
      check("mid_rst_hold", {31'b0, cpu_hold}, 32'd0);
      check("mid_rst_busy", {31'b0, busy}, 32'd0);
      check("mid_rst_addr", imem_addr, BASE);
      check("mid_rst_wdata", imem_wdata, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      fill_random(1);
      run_load(1, 0, 1'b0);

      // randomized loads with gaps and ignored start pulses
      for (int t = 0; t < 6; t++) begin
         len = int'($urandom_range(1, DEPTH));
         fill_random(len);
         run_load(len, 2, 1'b1);
      end

      check("final_err_count", 32'(err_seen), 32'd1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
